mc_control: RTL

- Multi-cycle control FSM for the bare 32-bit CPU. It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the ALU's ALUOp/BorN selects, the memory handshake, the register-file write enable and the PC/IR enables.
- Consumes the latched IR opcode, the ALU Branch_Flag and a memory-ready handshake.
- Counts retired instructions and traps on illegal opcodes and on memory timeouts.

---
 rtl/mc_pkg.sv | 60 ++++++
 rtl/mc_wait_timer.sv | 39 +++
 rtl/mc_control.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control FSM.
// Holds the state encoding, opcode constants, the ALUOp, PC_Src and Err_Code
// encodings, and opcode-class helper functions.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExec    = 4'd2,
        StAluWb   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWb   = 4'd6,
        StMemWr   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StHalt    = 4'd10,
        StError   = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpLw   = 6'h10;
    localparam logic [5:0] OpSw   = 6'h11;
    localparam logic [5:0] OpJmp  = 6'h18;
    localparam logic [5:0] OpHalt = 6'h3F;

    // ALU function select
    localparam logic [2:0] AluMov = 3'd0;
    localparam logic [2:0] AluAnd = 3'd1;
    localparam logic [2:0] AluAdd = 3'd2;
    localparam logic [2:0] AluSub = 3'd3;
    localparam logic [2:0] AluOr  = 3'd4;
    localparam logic [2:0] AluXor = 3'd5;
    localparam logic [2:0] AluSll = 3'd6;
    localparam logic [2:0] AluSlt = 3'd7;

    // PC source select
    localparam logic [1:0] PcSrcInc    = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    // Sticky error codes
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrIllegal = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    // Wait counter width; covers MEM_TIMEOUT up to 255
    localparam int unsigned WaitW = 8;

    // 0x00-0x0F: register and immediate ALU ops
    function automatic logic is_alu_op(input logic [5:0] op);
        return op[5:4] == 2'b00;
    endfunction

    // 0x14-0x17: conditional branches
    function automatic logic is_branch_op(input logic [5:0] op);
        return op[5:2] == 4'b0101;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and flags a bus timeout.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   active     - FSM is in a state that waits on memory
//   mem_ready  - memory completes this cycle
//   clear      - FSM changes state this cycle; restart the count
//   timeout    - this is the MEM_TIMEOUT-th consecutive not-ready cycle
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    input  logic clear,
    output logic timeout
);

    localparam logic [WaitW-1:0] Limit = WaitW'(MEM_TIMEOUT - 1);

    logic [WaitW-1:0] wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (clear || !active) begin
            wait_q <= '0;
        end else if (!mem_ready) begin
            wait_q <= wait_q + WaitW'(1);
        end
    end

    // Fires on the cycle whose not-ready would make the count reach MEM_TIMEOUT;
    // a Mem_Ready in that same cycle suppresses it.
    assign timeout = active && !mem_ready && (wait_q == Limit);

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the 32-bit CPU.
// Sequences FETCH -> DECODE -> EXEC/MEM/BRANCH/JUMP -> writeback, one
// instruction at a time, counts retired instructions and traps on illegal
// opcodes and memory timeouts.
// Ports:
//   Clk, Reset            - clock, asynchronous active-high reset
//   Opcode                - IR[31:26], valid from DECODE onward
//   Branch_Flag           - ALU compare result, used in BRANCH
//   Mem_Ready             - memory completes the current access
//   ALUOp, BorN, ALU_SrcB - ALU selects
//   Mem_Read, Mem_Write   - memory requests
//   IR_Write, PC_Write, PC_Src - IR/PC update controls
//   Reg_Write, Reg_Dst, Mem_to_Reg - register-file writeback controls
//   Halted, Err_Code      - stop indication and sticky error code
//   Instr_Count           - retired-instruction counter (wraps)
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Opcode,
    input  logic             Branch_Flag,
    input  logic             Mem_Ready,
    output logic [2:0]       ALUOp,
    output logic [1:0]       BorN,
    output logic             ALU_SrcB,
    output logic             Mem_Read,
    output logic             Mem_Write,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic [1:0]       PC_Src,
    output logic             Reg_Write,
    output logic             Reg_Dst,
    output logic             Mem_to_Reg,
    output logic             Halted,
    output logic [1:0]       Err_Code,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             wait_active;
    logic             timeout;

    assign wait_active = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (Clk),
        .rst      (Reset),
        .active   (wait_active),
        .mem_ready(Mem_Ready),
        .clear    (state_d != state_q),
        .timeout  (timeout)
    );

    // Next state, sticky error and retire strobe
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (Mem_Ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end
            end
            StDecode: begin
                // Decode uses the live Opcode; op_q is loaded on this same edge
                if (is_alu_op(Opcode)) begin
                    state_d = StExec;
                end else if (Opcode == OpLw || Opcode == OpSw) begin
                    state_d = StMemAddr;
                end else if (is_branch_op(Opcode)) begin
                    state_d = StBranch;
                end else if (Opcode == OpJmp) begin
                    state_d = StJump;
                end else if (Opcode == OpHalt) begin
                    state_d = StHalt;
                    retire  = 1'b1;
                end else begin
                    state_d = StError;
                    err_d   = ErrIllegal;
                end
            end
            StExec:    state_d = StAluWb;
            StAluWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd: begin
                if (Mem_Ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWr: begin
                if (Mem_Ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = StError;
                    err_d   = ErrTimeout;
                end
            end
            StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt, StError: state_d = state_q;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StFetch;
            op_q    <= '0;
            err_q   <= ErrNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == StDecode) begin
                op_q <= Opcode;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign Instr_Count = cnt_q;

    // Output decode from state_q/op_q; Reset forces everything low even though
    // the reset state is FETCH, which would otherwise raise Mem_Read.
    always_comb begin
        ALUOp      = AluMov;
        BorN       = 2'b00;
        ALU_SrcB   = 1'b0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        PC_Src     = PcSrcInc;
        Reg_Write  = 1'b0;
        Reg_Dst    = 1'b0;
        Mem_to_Reg = 1'b0;
        Halted     = 1'b0;
        Err_Code   = ErrNone;
        if (!Reset) begin
            Err_Code = err_q;
            unique case (state_q)
                StFetch: begin
                    Mem_Read = 1'b1;
                    IR_Write = Mem_Ready;
                    PC_Write = Mem_Ready;
                end
                StExec: begin
                    ALUOp    = op_q[2:0];
                    ALU_SrcB = op_q[3];
                end
                StAluWb: begin
                    ALUOp     = op_q[2:0];
                    ALU_SrcB  = op_q[3];
                    Reg_Write = 1'b1;
                    Reg_Dst   = ~op_q[3];
                end
                StMemAddr: begin
                    ALUOp    = AluAdd;
                    ALU_SrcB = 1'b1;
                end
                StMemRd: begin
                    ALUOp    = AluAdd;
                    ALU_SrcB = 1'b1;
                    Mem_Read = 1'b1;
                end
                StMemWb: begin
                    Reg_Write  = 1'b1;
                    Mem_to_Reg = 1'b1;
                end
                StMemWr: begin
                    ALUOp     = AluAdd;
                    ALU_SrcB  = 1'b1;
                    Mem_Write = 1'b1;
                end
                StBranch: begin
                    ALUOp    = AluSub;
                    BorN     = op_q[1:0];
                    PC_Write = Branch_Flag;
                    PC_Src   = PcSrcBranch;
                end
                StJump: begin
                    PC_Write = 1'b1;
                    PC_Src   = PcSrcJump;
                end
                StHalt, StError: Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
